ifft_twiddle_mul: RTL

IFFT_TWIDDLE_MUL -- requirements
Module: ifft_twiddle_mul

---
 rtl/ifft_pkg.sv | 45 ++++
 rtl/ifft_twiddle_rom.sv | 30 +++
 rtl/ifft_twiddle_mul.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ifft_pkg.sv
// Shared constants and the quarter-wave twiddle table for the IFFT twiddle multiplier.
package ifft_pkg;

    localparam int N     = 32;
    localparam int DW    = 36;
    localparam int CW    = 18;
    localparam int SHIFT = 16;
    localparam int RND   = 1 << (SHIFT - 1);
    // Transform size the built-in coefficient table is sampled for.
    localparam int TBL_N = 32;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } twiddle_t;

    // round(65536*cos(2*pi*q/32)) for the first quarter wave, q = 0..8.
    function automatic logic signed [CW-1:0] qcos(input logic [3:0] q);
        logic signed [CW-1:0] v;
        case (q)
            4'd0:    v = 18'sd65536;
            4'd1:    v = 18'sd64277;
            4'd2:    v = 18'sd60547;
            4'd3:    v = 18'sd54491;
            4'd4:    v = 18'sd46341;
            4'd5:    v = 18'sd36410;
            4'd6:    v = 18'sd25080;
            4'd7:    v = 18'sd12785;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Full W^idx for a 32-point inverse transform, idx = 0..15, built from the quarter wave.
    function automatic twiddle_t tw32(input logic [3:0] idx);
        twiddle_t   t;
        logic [3:0] m;
        if (idx <= 4'd8) t.re = qcos(idx);
        else             t.re = -qcos(4'd0 - idx);
        m    = (idx >= 4'd8) ? (idx - 4'd8) : (4'd8 - idx);
        t.im = qcos(m);
        return t;
    endfunction

endpackage

// File: rtl/ifft_twiddle_rom.sv
// Registered cos/sin twiddle lookup addressed by the twiddle index k.
module ifft_twiddle_rom #(
    parameter int N  = ifft_pkg::N,
    parameter int CW = ifft_pkg::CW,
    localparam int KW = $clog2(N / 2)
) (
    input  logic                 clk,
    input  logic [KW-1:0]        addr,
    output logic signed [CW-1:0] cos_q,
    output logic signed [CW-1:0] sin_q
);
    import ifft_pkg::*;

    // Smaller power-of-two sizes stride through the 32-point table.
    localparam int STEP = TBL_N / N;
    localparam int SH   = $clog2(STEP);

    logic [3:0] idx32;
    twiddle_t   tw;

    assign idx32 = 4'(addr) << SH;
    assign tw    = tw32(idx32);

    // Table output register; holds coefficient data only, so no reset.
    always_ff @(posedge clk) begin
        cos_q <= CW'(tw.re);
        sin_q <= CW'(tw.im);
    end

endmodule

// File: rtl/ifft_twiddle_mul.sv
// Three-stage twiddle multiplier following an IFFT butterfly: the lower output is
// rotated by W^k = exp(+j*2*pi*k/N), the upper output is delayed to match.
module ifft_twiddle_mul #(
    parameter int N  = ifft_pkg::N,
    parameter int DW = ifft_pkg::DW,
    parameter int CW = ifft_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] di1r,
    input  logic signed [DW-1:0] di1i,
    input  logic signed [DW-1:0] di2r,
    input  logic signed [DW-1:0] di2i,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic signed [DW-1:0] do1r,
    output logic signed [DW-1:0] do1i,
    output logic signed [DW-1:0] do2r,
    output logic signed [DW-1:0] do2i
);
    import ifft_pkg::*;

    localparam int KW = $clog2(N / 2);
    localparam int PW = DW + CW;
    localparam int SW = PW + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);

    // Round half up at bit SHIFT-1, arithmetic shift, keep the low DW bits (wraps on overflow).
    function automatic logic signed [DW-1:0] round_shift(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = s + SW'(RND);
        t = t >>> SHIFT;
        return t[DW-1:0];
    endfunction

    logic [KW-1:0] k;
    logic [KW-1:0] k_sel;

    logic                 vld_p0, sof_p0;
    logic signed [DW-1:0] d1r_p0, d1i_p0, d2r_p0, d2i_p0;
    logic signed [CW-1:0] cos_p0, sin_p0;

    logic                 vld_p1, sof_p1;
    logic signed [DW-1:0] d1r_p1, d1i_p1;
    logic signed [PW-1:0] rc_p1, is_p1, rs_p1, ic_p1;

    logic signed [SW-1:0] re_sum, im_sum;

    // A start-of-frame pair always takes k = 0, whatever the running count is.
    assign k_sel = (in_valid && in_sof) ? '0 : k;

    // Twiddle index: advances once per accepted pair and wraps at N/2.
    always_ff @(posedge clk) begin
        if (!rst)          k <= '0;
        else if (in_valid) k <= (k_sel == K_LAST) ? '0 : k_sel + KW'(1);
    end

    // ---- stage 1: input register plus table read ----
    ifft_twiddle_rom #(.N(N), .CW(CW)) u_rom (
        .clk   (clk),
        .addr  (k_sel),
        .cos_q (cos_p0),
        .sin_q (sin_p0)
    );

    // Stage 1 control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            sof_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            sof_p0 <= in_valid & in_sof;
        end
    end

    // Stage 1 data capture on accepted pairs.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            d1r_p0 <= di1r;
            d1i_p0 <= di1i;
            d2r_p0 <= di2r;
            d2i_p0 <= di2i;
        end
    end

    // ---- stage 2: four full-precision products ----
    // Stage 2 control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            sof_p1 <= sof_p0;
        end
    end

    // Stage 2 products and upper-path delay.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            rc_p1  <= d2r_p0 * cos_p0;
            is_p1  <= d2i_p0 * sin_p0;
            rs_p1  <= d2r_p0 * sin_p0;
            ic_p1  <= d2i_p0 * cos_p0;
            d1r_p1 <= d1r_p0;
            d1i_p1 <= d1i_p0;
        end
    end

    // ---- stage 3: add, round, output register ----
    assign re_sum = SW'(rc_p1) - SW'(is_p1);
    assign im_sum = SW'(rs_p1) + SW'(ic_p1);

    // Stage 3 control outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            out_sof   <= sof_p1;
        end
    end

    // Stage 3 data outputs: cleared by reset, otherwise hold until a valid pair leaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            do1r <= '0;
            do1i <= '0;
            do2r <= '0;
            do2i <= '0;
        end else if (vld_p1) begin
            do1r <= d1r_p1;
            do1i <= d1i_p1;
            do2r <= round_shift(re_sum);
            do2i <= round_shift(im_sum);
        end
    end

endmodule
